// File: rtl/bus_timer_pkg.sv
// Shared definitions for the bus_timer slave: bus widths, strobe polarities,
// register indices, control bit positions and handshake FSM states.
package bus_timer_pkg;

  localparam int unsigned WORD_ADDR_W = 30;
  localparam int unsigned WORD_DATA_W = 32;

  typedef logic [WORD_ADDR_W-1:0] word_addr_t;
  typedef logic [WORD_DATA_W-1:0] word_data_t;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;
  localparam logic READ     = 1'b1;
  localparam logic WRITE    = 1'b0;

  localparam int unsigned TIMER_ADDR_MSB = 1;
  localparam int unsigned TIMER_ADDR_LSB = 0;

  typedef logic [TIMER_ADDR_MSB:TIMER_ADDR_LSB] timer_addr_t;

  localparam timer_addr_t TIMER_ADDR_CTRL    = 2'd0;
  localparam timer_addr_t TIMER_ADDR_INTR    = 2'd1;
  localparam timer_addr_t TIMER_ADDR_EXPR    = 2'd2;
  localparam timer_addr_t TIMER_ADDR_COUNTER = 2'd3;

  localparam int unsigned TIMER_START_LOC = 0;
  localparam int unsigned TIMER_MODE_LOC  = 1;
  localparam int unsigned TIMER_IRQ_LOC   = 0;

  typedef enum logic [1:0] {
    HS_IDLE = 2'd0,
    HS_WAIT = 2'd1,
    HS_ACK  = 2'd2
  } hs_state_t;

  function automatic word_data_t timer_rd_mux(
    input timer_addr_t sel,
    input logic        start,
    input logic        mode,
    input logic        irq_flag,
    input word_data_t  expr,
    input word_data_t  counter
  );
    word_data_t d;
    d = '0;
    case (sel)
      TIMER_ADDR_CTRL: begin
        d[TIMER_START_LOC] = start;
        d[TIMER_MODE_LOC]  = mode;
      end
      TIMER_ADDR_INTR:    d[TIMER_IRQ_LOC] = irq_flag;
      TIMER_ADDR_EXPR:    d = expr;
      TIMER_ADDR_COUNTER: d = counter;
      default:            d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/bus_slave_hs.sv
// Generic slave-bus handshake: accepts a strobed request in IDLE, inserts
// WAIT_CYC wait states, then presents a single ACK cycle.
module bus_slave_hs
  import bus_timer_pkg::*;
#(
  parameter int unsigned WAIT_CYC = 0
) (
  input  logic clk,
  input  logic reset_,
  input  logic cs_,
  input  logic as_,
  output logic accept,
  output logic ack,
  output logic ack_load
);

  hs_state_t  state, state_nxt;
  logic [3:0] wait_cnt, wait_cnt_nxt;
  logic       req;

  assign req = (cs_ == ENABLE_) && (as_ == ENABLE_);

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state    <= HS_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      HS_IDLE: begin
        if (req) begin
          if (WAIT_CYC == 0) begin
            state_nxt = HS_ACK;
          end else begin
            state_nxt    = HS_WAIT;
            wait_cnt_nxt = 4'(WAIT_CYC - 1);
          end
        end
      end
      HS_WAIT: begin
        if (wait_cnt == '0) state_nxt = HS_ACK;
        else                wait_cnt_nxt = wait_cnt - 4'd1;
      end
      HS_ACK:  state_nxt = HS_IDLE;
      default: state_nxt = HS_IDLE;
    endcase
  end

  // ack_load marks the edge entering ACK, where the read data is registered.
  always_comb begin
    accept   = (state == HS_IDLE) && req;
    ack      = (state == HS_ACK);
    ack_load = (state_nxt == HS_ACK);
  end

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped interval timer slave: CTRL/INTR/EXPR/COUNTER registers,
// one-shot or periodic expiry with a level interrupt.
module bus_timer
  import bus_timer_pkg::*;
#(
  parameter int unsigned WAIT_CYC = 0
) (
  input  logic                   clk,
  input  logic                   reset_,
  input  logic                   cs_,
  input  logic                   as_,
  input  logic                   rw,
  input  logic [WORD_ADDR_W-1:0] addr,
  input  logic [WORD_DATA_W-1:0] wr_data,
  output logic [WORD_DATA_W-1:0] rd_data,
  output logic                   rdy_,
  output logic                   irq
);

  logic        accept, ack, ack_load;
  logic        start, mode, irq_flag;
  word_data_t  expr, counter;
  timer_addr_t sel, req_addr, rd_sel;
  logic        req_rw, rd_rw;
  logic        wr_en, expire;
  logic        unused_addr;

  bus_slave_hs #(
    .WAIT_CYC (WAIT_CYC)
  ) u_hs (
    .clk      (clk),
    .reset_   (reset_),
    .cs_      (cs_),
    .as_      (as_),
    .accept   (accept),
    .ack      (ack),
    .ack_load (ack_load)
  );

  assign sel         = addr[TIMER_ADDR_MSB:TIMER_ADDR_LSB];
  assign unused_addr = ^addr[WORD_ADDR_W-1:TIMER_ADDR_MSB+1];
  assign wr_en       = accept && (rw == WRITE);
  assign expire      = start && (counter == expr);

  // With zero wait states acceptance and ACK entry share one edge, so the
  // live request is used then; otherwise the latched copy.
  assign rd_sel = accept ? sel : req_addr;
  assign rd_rw  = accept ? rw  : req_rw;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      req_addr <= '0;
      req_rw   <= READ;
    end else if (accept) begin
      req_addr <= sel;
      req_rw   <= rw;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      start    <= 1'b0;
      mode     <= 1'b0;
      irq_flag <= 1'b0;
      expr     <= '0;
      counter  <= '0;
    end else begin
      if (wr_en && sel == TIMER_ADDR_CTRL) begin
        start <= wr_data[TIMER_START_LOC];
        mode  <= wr_data[TIMER_MODE_LOC];
      end else if (expire && !mode) begin
        start <= 1'b0;
      end

      if (expire) begin
        irq_flag <= 1'b1;
      end else if (wr_en && sel == TIMER_ADDR_INTR && !wr_data[TIMER_IRQ_LOC]) begin
        irq_flag <= 1'b0;
      end

      if (wr_en && sel == TIMER_ADDR_EXPR) expr <= wr_data;

      if (wr_en && sel == TIMER_ADDR_COUNTER) counter <= wr_data;
      else if (expire)                        counter <= '0;
      else if (start)                         counter <= counter + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      rd_data <= '0;
    end else if (ack_load && rd_rw == READ) begin
      rd_data <= timer_rd_mux(rd_sel, start, mode, irq_flag, expr, counter);
    end else begin
      rd_data <= '0;
    end
  end

  always_comb begin
    rdy_ = ack ? ENABLE_ : DISABLE_;
    irq  = irq_flag;
  end

endmodule
